// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grant between the ALU (A) and load-return (B)
// paths onto the register file's single write port, with a registered output stage.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   HOLD,
    input  logic                   A_VALID,
    input  logic [ADDR_W-1:0]      A_ADDR,
    input  logic [DATA_W-1:0]      A_DATA,
    output logic                   A_READY,
    input  logic                   B_VALID,
    input  logic [ADDR_W-1:0]      B_ADDR,
    input  logic [DATA_W-1:0]      B_DATA,
    output logic                   B_READY,
    output logic                   WRITE,
    output logic [ADDR_W-1:0]      WRADDRESS,
    output logic [DATA_W-1:0]      IN,
    output logic [2**ADDR_W-1:0]   PENDING
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t              last_q, last_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  wraddr_q, wraddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               grant_a, grant_b;

    // On a conflict the requester that did not win last time goes first.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!RESET && !HOLD) begin
            if (A_VALID && (!B_VALID || last_q == LAST_B)) begin
                grant_a = 1'b1;
            end else if (B_VALID) begin
                grant_b = 1'b1;
            end
        end
    end

    assign A_READY = grant_a;
    assign B_READY = grant_b;

    always_comb begin
        last_d   = last_q;
        write_d  = 1'b0;
        wraddr_d = wraddr_q;
        wdata_d  = wdata_q;
        if (grant_a) begin
            last_d   = LAST_A;
            write_d  = 1'b1;
            wraddr_d = A_ADDR;
            wdata_d  = A_DATA;
        end else if (grant_b) begin
            last_d   = LAST_B;
            write_d  = 1'b1;
            wraddr_d = B_ADDR;
            wdata_d  = B_DATA;
        end
    end

    // Reset drops any write sitting in the output stage.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_q   <= LAST_B;
            write_q  <= 1'b0;
            wraddr_q <= '0;
            wdata_q  <= '0;
        end else begin
            last_q   <= last_d;
            write_q  <= write_d;
            wraddr_q <= wraddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign WRITE     = write_q;
    assign WRADDRESS = wraddr_q;
    assign IN        = wdata_q;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
        assign PENDING[gi] = write_q && (wraddr_q == ADDR_W'(gi));
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the 8 x 32-bit register file. Two producers share the file's single write port: requester A (ALU result path) and requester B (load/memory return path). The block grants one requester per cycle with round-robin fairness and registers the winning write into the WRITE / WRADDRESS / IN port of the register file. It also exports a one-hot pending-write vector so the issue logic can detect read-after-write hazards.

## Interface
Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 3, register address width (8 registers)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high
- HOLD  in  1  stall; when 1, no new grants are issued
- A_VALID  in  1  requester A has a write pending
- A_ADDR  in  ADDR_W  destination register of A
- A_DATA  in  DATA_W  write data of A
- A_READY  out  1  A's write is accepted this cycle
- B_VALID  in  1  requester B has a write pending
- B_ADDR  in  ADDR_W  destination register of B
- B_DATA  in  DATA_W  write data of B
- B_READY  out  1  B's write is accepted this cycle
- WRITE  out  1  write enable to the register file
- WRADDRESS  out  ADDR_W  write address to the register file
- IN  out  DATA_W  write data to the register file
- PENDING  out  2**ADDR_W  one-hot mask of the register being written this cycle

## Operation
- Handshake: a transfer occurs in any cycle where X_VALID=1 and X_READY=1.
  - A requester holds VALID, ADDR and DATA stable until READY.
  - VALID is never withdrawn before acceptance.
- Grant logic is combinational from VALIDs, HOLD, RESET and LAST.
  - RESET=1 or HOLD=1: A_READY=B_READY=0.
  - Only A valid: A granted. Only B valid: B granted.
  - Both valid: the requester not named in LAST is granted.
  - A_READY and B_READY are never both 1.
- LAST is a 1-bit state register (A or B).
  - Reset value: B, so A wins the first conflict.
  - Updated to the granted requester on every transfer.
  - Held when no transfer occurs.
- Output stage is registered. On a transfer:
  - WRITE<=1, WRADDRESS<=granted ADDR, IN<=granted DATA.
  - With no transfer: WRITE<=0; WRADDRESS and IN hold their values.
- PENDING = WRITE ? (1 << WRADDRESS) : 0, combinational from the output registers.
- Both requesters valid with the same address: no merging. Writes are serialized in grant order, and the later grant's data ends up in the register.
- The block does not reset the register file contents. The file resets itself on RESET.

## Timing
- Reset (RESET=1 at an edge): WRITE=0, WRADDRESS=0, IN=0, LAST=B, PENDING=0. A_READY and B_READY are 0 combinationally while RESET=1.
- Reset mid-operation: any write in the output stage is dropped (WRITE=0 after the edge). Requests outstanding during reset are not granted until the first cycle with RESET=0.
- Latency: transfer in cycle t produces WRITE=1 during cycle t+1, and the register file captures IN at the end of t+1. Data is readable combinationally from the file in cycle t+2.
- Throughput: one write per cycle, back-to-back, with no bubbles.
- Fairness: with both VALIDs held high, grants alternate A,B,A,B... A requester waits at most 1 cycle while the other is valid.
- HOLD=1 in cycle t: no transfer in t, WRITE=0 in t+1. A write already registered in cycle t still completes (WRITE stays 1 through t).
- HOLD does not alter LAST.

## Test plan
- Reset: assert RESET for 2 cycles with A_VALID=B_VALID=1 -> READYs 0, WRITE=0, WRADDRESS=0, IN=0, PENDING=0. First post-reset cycle grants A.
- Single requester: A writes 32'hDEADBEEF to r3 in cycle t -> WRITE=1, WRADDRESS=3, IN=32'hDEADBEEF, PENDING=8'h08 in t+1. Reading r3 in t+2 returns DEADBEEF.
- Conflict round-robin: both valid continuously for 6 cycles, A=(r1,i) and B=(r2,100+i) -> grant sequence A,B,A,B,A,B. WRITE is high on 6 consecutive cycles.
- Same address: A=(r5,32'h1111) and B=(r5,32'h2222) valid together from reset -> A written first, then B. r5 ends at 32'h2222.
- HOLD: both valid, HOLD=1 for 3 cycles -> no READY and WRITE=0 from the cycle after HOLD rises. On HOLD release the grant goes to the requester not in LAST.
- Reset mid-stream: RESET in the cycle after a B transfer to r6 -> WRITE=0 after the edge, LAST=B. The next conflict grants A.
